resonator_dds_phase_acc: RTL and testbench

Time-multiplexed per-channel phase accumulator at the head of the resonator DDS. Each clock-enabled cycle it serves one channel in round-robin order. It adds that channel's programmed frequency increment to the stored phase. It then splits the pre-add phase into a sine-LUT address and a 16-bit unsigned residual. The residual feeds the unsigned 16-bit operand of the downstream 16x18 signed interpolation multiplier; the address drives the sine/slope LUT.

---
 rtl/resonator_dds_pkg.sv | 26 ++
 rtl/resonator_dds_phase_acc_if.sv | 29 ++
 rtl/resonator_dds_phase_ram.sv | 31 +++
 rtl/resonator_dds_phase_acc.sv | 94 +++++++++
 tb/tb_resonator_dds_phase_acc.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/resonator_dds_pkg.sv
// Shared types, widths and phase-field slice helpers
// for the resonator DDS phase accumulator.
package resonator_dds_pkg;

  localparam int N_CHAN   = 256;
  localparam int PHASE_W  = 32;
  localparam int ADDR_W   = 10;
  localparam int RES_W    = 16;
  localparam int CHAN_W   = $clog2(N_CHAN);
  localparam int ADDR_LSB = PHASE_W - ADDR_W;
  localparam int RES_LSB  = ADDR_LSB - RES_W;

  typedef logic [CHAN_W-1:0]  chan_t;
  typedef logic [PHASE_W-1:0] phase_t;
  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [RES_W-1:0]   resid_t;

  function automatic addr_t phase_addr(phase_t p);
    return p[PHASE_W-1 -: ADDR_W];
  endfunction

  function automatic resid_t phase_resid(phase_t p);
    return p[ADDR_LSB-1 -: RES_W];
  endfunction

endpackage

// File: rtl/resonator_dds_phase_acc_if.sv
// Increment-write, sync/enable and output bundle
// of the DDS phase accumulator.
interface resonator_dds_phase_acc_if;
  import resonator_dds_pkg::*;

  logic   ce;
  logic   inc_we;
  chan_t  inc_chan;
  phase_t inc_data;
  logic   sync;
  logic   out_valid;
  chan_t  out_chan;
  logic   out_first;
  addr_t  out_addr;
  resid_t out_resid;

  modport master (
    output ce, inc_we, inc_chan, inc_data, sync,
    input  out_valid, out_chan, out_first,
    input  out_addr, out_resid
  );

  modport slave (
    input  ce, inc_we, inc_chan, inc_data, sync,
    output out_valid, out_chan, out_first,
    output out_addr, out_resid
  );

endinterface

// File: rtl/resonator_dds_phase_ram.sv
// Simple dual-port RAM with registered, enabled read
// and optional write-first bypass on address match.
module resonator_dds_phase_ram
  import resonator_dds_pkg::*;
#(
  parameter int DEPTH  = N_CHAN,
  parameter int WIDTH  = PHASE_W,
  parameter bit BYPASS = 1'b0
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             hit;

  assign hit = BYPASS && we && (waddr == raddr);

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
    if (re)
      rdata <= hit ? wdata : mem[raddr];
  end

endmodule

// File: rtl/resonator_dds_phase_acc.sv
// Round-robin per-channel phase accumulator feeding
// the sine LUT address and interpolation residual.
module resonator_dds_phase_acc
  import resonator_dds_pkg::*;
(
  input logic                      clk,
  input logic                      reset_n,
  resonator_dds_phase_acc_if.slave bus
);

  chan_t  chan_cnt;
  chan_t  s1_chan;
  logic   sync_pend;
  logic   clr;
  logic   clr_now;
  logic   s1_clr;
  logic   s1_valid;
  phase_t inc_rd;
  phase_t phase_rd;
  phase_t base;
  phase_t next;

  // clr is latched per frame; chan 0 decides it
  assign clr_now = (chan_cnt == '0) ? sync_pend : clr;
  assign base    = (s1_clr || !s1_valid) ? '0 : phase_rd;
  assign next    = base + inc_rd;

  resonator_dds_phase_ram #(
    .BYPASS (1'b1)
  ) u_inc (
    .clk   (clk),
    .we    (bus.inc_we),
    .waddr (bus.inc_chan),
    .wdata (bus.inc_data),
    .re    (bus.ce),
    .raddr (chan_cnt),
    .rdata (inc_rd)
  );

  resonator_dds_phase_ram #(
    .BYPASS (1'b0)
  ) u_phase (
    .clk   (clk),
    .we    (bus.ce && s1_valid),
    .waddr (s1_chan),
    .wdata (next),
    .re    (bus.ce),
    .raddr (chan_cnt),
    .rdata (phase_rd)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_pend <= 1'b0;
    end else if (bus.ce && chan_cnt == '0) begin
      sync_pend <= bus.sync;
    end else if (bus.sync) begin
      sync_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chan_cnt <= '0;
      clr      <= 1'b0;
      s1_chan  <= '0;
      s1_clr   <= 1'b0;
      s1_valid <= 1'b0;
    end else if (bus.ce) begin
      chan_cnt <= chan_cnt + 1'b1;
      clr      <= clr_now;
      s1_chan  <= chan_cnt;
      s1_clr   <= clr_now;
      s1_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.out_valid <= 1'b0;
      bus.out_chan  <= '0;
      bus.out_first <= 1'b0;
      bus.out_addr  <= '0;
      bus.out_resid <= '0;
    end else if (bus.ce) begin
      bus.out_valid <= s1_valid;
      bus.out_chan  <= s1_chan;
      bus.out_first <= s1_valid && (s1_chan == '0);
      bus.out_addr  <= phase_addr(base);
      bus.out_resid <= phase_resid(base);
    end
  end

endmodule

// File: tb/tb_resonator_dds_phase_acc.sv
// Directed bench for the DDS phase accumulator:
// sync/clr frames, residual, wrap, bypass, ce hold.
module tb_resonator_dds_phase_acc;
  import resonator_dds_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  resonator_dds_phase_acc_if bus ();

  resonator_dds_phase_acc dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic next_out(input int c);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.out_valid === 1'b1 &&
                 bus.out_chan == chan_t'(c)) && n < 1000);
    tests++;
    assert (n < 1000) else begin
      fails++;
      $error("FAIL wait_ch%0d got=%0d cycles want<1000", c, n);
    end
  endtask

  function automatic phase_t inc_of(input int c);
    case (c)
      0:       return 32'hC000_0000;
      3:       return 32'h0100_0000;
      5:       return 32'h0000_0040;
      200:     return 32'h0040_0000;
      default: return 32'h0;
    endcase
  endfunction

  logic [9:0]  ch0_tab [5] = '{10'h0, 10'h300, 10'h200,
                                10'h100, 10'h0};
  logic [7:0]  pc;
  logic [7:0]  nc;
  logic [9:0]  pa;
  logic [9:0]  a0;
  logic [9:0]  a1;
  logic [15:0] pr;
  logic        e;

  initial begin
    bus.ce       = 1'b0;
    bus.inc_we   = 1'b0;
    bus.inc_chan = '0;
    bus.inc_data = '0;
    bus.sync     = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_chan",  32'(bus.out_chan),  32'd0);
    chk("rst_first", 32'(bus.out_first), 32'd0);
    chk("rst_addr",  32'(bus.out_addr),  32'd0);
    chk("rst_resid", 32'(bus.out_resid), 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < N_CHAN; i++) begin
      bus.inc_we   = 1'b1;
      bus.inc_chan = chan_t'(i);
      bus.inc_data = inc_of(i);
      @(negedge clk);
    end
    bus.inc_we = 1'b0;
    chk("ce0_valid", 32'(bus.out_valid), 32'd0);

    bus.ce   = 1'b1;
    bus.sync = 1'b1;
    @(negedge clk);
    bus.sync = 1'b0;
    next_out(0);
    chk("f1_first", 32'(bus.out_first), 32'd1);

    for (int k = 0; k < 5; k++) begin
      next_out(0);
      chk("ch0_addr", 32'(bus.out_addr), 32'(ch0_tab[k]));
      chk("ch0_first", 32'(bus.out_first), 32'd1);
      next_out(1);
      chk("ch1_addr", 32'(bus.out_addr), 32'd0);
      chk("ch1_first", 32'(bus.out_first), 32'd0);
      next_out(3);
      chk("ch3_addr", 32'(bus.out_addr), 32'(k * 4));
      next_out(5);
      chk("ch5_resid", 32'(bus.out_resid), 32'(k));
      chk("ch5_addr", 32'(bus.out_addr), 32'd0);
    end

    next_out(5);
    bus.inc_we   = 1'b1;
    bus.inc_chan = chan_t'(7);
    bus.inc_data = 32'h0040_0000;
    @(negedge clk);
    bus.inc_we = 1'b0;
    next_out(7);
    chk("byp_pre", 32'(bus.out_addr), 32'd0);
    next_out(7);
    chk("byp_used", 32'(bus.out_addr), 32'd1);

    for (int i = 0; i < 400; i++) begin
      pc = bus.out_chan;
      pa = bus.out_addr;
      pr = bus.out_resid;
      e  = 1'($urandom_range(0, 1));
      bus.ce = e;
      @(negedge clk);
      if (e) begin
        nc = pc + 8'd1;
        chk("ce_chan", 32'(bus.out_chan), 32'(nc));
      end else begin
        chk("hold_chan", 32'(bus.out_chan), 32'(pc));
        chk("hold_addr", 32'(bus.out_addr), 32'(pa));
        chk("hold_resid", 32'(bus.out_resid), 32'(pr));
      end
    end
    bus.ce = 1'b1;

    next_out(200);
    a0 = bus.out_addr;
    next_out(98);
    bus.sync = 1'b1;
    @(negedge clk);
    bus.sync = 1'b0;
    next_out(200);
    a1 = a0 + 10'd1;
    chk("mid_keep", 32'(bus.out_addr), 32'(a1));
    next_out(0);
    chk("clr1_ch0", 32'(bus.out_addr), 32'd0);
    next_out(3);
    chk("clr1_ch3", 32'(bus.out_addr), 32'd0);
    next_out(50);
    bus.sync = 1'b1;
    @(negedge clk);
    bus.sync = 1'b0;
    next_out(200);
    chk("clr1_ch200", 32'(bus.out_addr), 32'd0);
    next_out(0);
    chk("clr2_ch0", 32'(bus.out_addr), 32'd0);
    next_out(3);
    chk("clr2_ch3", 32'(bus.out_addr), 32'd0);
    next_out(200);
    chk("clr2_ch200", 32'(bus.out_addr), 32'd0);
    next_out(0);
    chk("post_ch0", 32'(bus.out_addr), 32'h300);
    next_out(3);
    chk("post_ch3", 32'(bus.out_addr), 32'd4);
    next_out(200);
    chk("post_ch200", 32'(bus.out_addr), 32'd1);

    next_out(120);
    reset_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(bus.out_valid), 32'd0);
    chk("mrst_chan", 32'(bus.out_chan), 32'd0);
    chk("mrst_addr", 32'(bus.out_addr), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("mrst_v1", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("mrst_v2", 32'(bus.out_valid), 32'd1);
    chk("mrst_ch", 32'(bus.out_chan), 32'd0);
    chk("mrst_first", 32'(bus.out_first), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
